// File: rtl/l2_arbiter_pkg.sv
// Shared LC-3b cache types plus the L2 arbiter FSM state encoding.
// Latency: none (types only).
// Backpressure: n/a.
package lc3b_types;

    localparam int LC3B_LINE_BITS = 128;

    typedef logic [LC3B_LINE_BITS-1:0] lc3b_cache_line;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } l2_arb_state_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of per-requester handshakes plus the shared L2 memory port.
// Latency: none (wiring only).
// Backpressure: requesters hold read/write until their resp pulse; L2 may stall indefinitely.
interface l2_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    import lc3b_types::*;

    logic [NUM_PORTS-1:0]            port_read;
    logic [NUM_PORTS-1:0]            port_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata;
    logic [NUM_PORTS-1:0]            port_resp;
    logic [LINE_WIDTH-1:0]           port_rdata;

    logic [ADDR_WIDTH-1:0]           l2_address;
    logic                            l2_read;
    logic                            l2_write;
    logic [LINE_WIDTH-1:0]           l2_wdata;
    logic                            l2_mem_resp;
    logic [LINE_WIDTH-1:0]           l2_rdata;

    // Arbiter view: consumes requests and L2 completions, drives strobes and responses.
    modport slave (
        input  port_read, port_write, port_address, port_wdata,
        input  l2_mem_resp, l2_rdata,
        output port_resp, port_rdata,
        output l2_address, l2_read, l2_write, l2_wdata
    );

    // Environment view: L1 requesters plus the L2 memory.
    modport master (
        output port_read, port_write, port_address, port_wdata,
        output l2_mem_resp, l2_rdata,
        input  port_resp, port_rdata,
        input  l2_address, l2_read, l2_write, l2_wdata
    );

endinterface

// File: rtl/l2_arbiter_rr_select.sv
// Rotating-priority selector: first requester at or after i_base, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of the request vector.
module rr_select #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_base,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    // Walk the ports starting at the base index and take the first requester.
    always_comb begin
        logic [IDX_W:0] w_cand;
        logic           w_found;
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = {1'b0, i_base} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_PORTS)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_PORTS);
            end
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found                  = 1'b1;
                o_idx                    = w_cand[IDX_W-1:0];
                o_grant[w_cand[IDX_W-1:0]] = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one line-wide L2 port among NUM_PORTS L1 requesters, one transaction at a time.
// Latency: strobe 1 cycle after request sampled; resp 1 cycle after l2_mem_resp; 3-cycle turnaround.
// Backpressure: losers and the winner hold requests; L2 stalls by withholding l2_mem_resp.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int ARB_MODE   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    l2_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    l2_arb_state_t r_state;
    l2_arb_state_t w_next_state;

    logic [IDX_W-1:0]      r_grant;
    logic [NUM_PORTS-1:0]  r_grant_oh;
    logic [IDX_W-1:0]      r_last_grant;
    logic [ADDR_WIDTH-1:0] r_l2_address;
    logic [LINE_WIDTH-1:0] r_l2_wdata;
    logic                  r_l2_read;
    logic                  r_l2_write;
    logic [NUM_PORTS-1:0]  r_port_resp;
    logic [LINE_WIDTH-1:0] r_port_rdata;

    logic [NUM_PORTS-1:0]  w_req;
    logic [IDX_W-1:0]      w_base;
    logic [NUM_PORTS-1:0]  w_win_oh;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [LINE_WIDTH-1:0] w_win_wdata;
    logic                  w_win_write;

    assign w_req = bus.port_read | bus.port_write;

    // Fixed priority always searches from port 0; round-robin starts just past the last winner.
    assign w_base = (ARB_MODE == 1)          ? '0 :
                    (r_last_grant == LAST_IDX) ? '0 :
                    r_last_grant + IDX_W'(1);

    rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .i_req   (w_req),
        .i_base  (w_base),
        .o_grant (w_win_oh),
        .o_idx   (w_win_idx),
        .o_any   (w_any)
    );

    assign w_win_addr  = bus.port_address[32'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_wdata = bus.port_wdata[32'(w_win_idx)*LINE_WIDTH +: LINE_WIDTH];
    // Write wins when a port raises both read and write.
    assign w_win_write = bus.port_write[w_win_idx];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant in IDLE, wait for L2 in ISSUE, single response cycle in DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = ISSUE;
            ISSUE:   if (bus.l2_mem_resp) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the winner's transaction, hold it through ISSUE, and capture the L2 reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_grant_oh   <= '0;
            r_last_grant <= LAST_IDX;
            r_l2_address <= '0;
            r_l2_wdata   <= '0;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_port_resp  <= '0;
            r_port_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_win_idx;
                        r_grant_oh   <= w_win_oh;
                        r_l2_address <= w_win_addr;
                        r_l2_wdata   <= w_win_wdata;
                        r_l2_write   <= w_win_write;
                        r_l2_read    <= ~w_win_write;
                    end
                end
                ISSUE: begin
                    if (bus.l2_mem_resp) begin
                        r_port_rdata <= bus.l2_rdata;
                        r_l2_read    <= 1'b0;
                        r_l2_write   <= 1'b0;
                        r_port_resp  <= r_grant_oh;
                        r_last_grant <= r_grant;
                    end
                end
                DONE: begin
                    r_port_resp <= '0;
                end
                default: begin
                    r_port_resp <= '0;
                end
            endcase
        end
    end

    assign bus.l2_address = r_l2_address;
    assign bus.l2_wdata   = r_l2_wdata;
    assign bus.l2_read    = r_l2_read;
    assign bus.l2_write   = r_l2_write;
    assign bus.port_resp  = r_port_resp;
    assign bus.port_rdata = r_port_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: round-robin 2-port, fixed-priority 2-port, round-robin 4-port.
// Each DUT has a simple L2 responder answering after a programmable number of strobe cycles.
// Read data returned by L2 is {8{address}} ^ key so each transaction's line is distinct.
module tb_l2_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    l2_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) a2 ();
    l2_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128)) afp ();
    l2_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128)) a4 ();

    l2_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .ARB_MODE(0))
        u_rr (.clk(clk), .rst_n(rst_n), .bus(a2));
    l2_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .ARB_MODE(1))
        u_fp (.clk(clk), .rst_n(rst_n), .bus(afp));
    l2_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .LINE_WIDTH(128), .ARB_MODE(0))
        u_p4 (.clk(clk), .rst_n(rst_n), .bus(a4));

    int           lat_rr = 5, lat_fp = 3, lat_p4 = 2;
    int           cnt_rr, cnt_fp, cnt_p4;
    logic [127:0] key_rr = '0;

    // L2 models: pulse l2_mem_resp once the strobe has been seen for lat cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_rr = 0; a2.l2_mem_resp = 1'b0; a2.l2_rdata = '0;
        end else if (a2.l2_mem_resp) begin
            a2.l2_mem_resp = 1'b0; cnt_rr = 0;
        end else if (a2.l2_read || a2.l2_write) begin
            cnt_rr++;
            if (cnt_rr >= lat_rr) begin
                a2.l2_mem_resp = 1'b1;
                a2.l2_rdata    = {8{a2.l2_address}} ^ key_rr;
            end
        end else cnt_rr = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_fp = 0; afp.l2_mem_resp = 1'b0; afp.l2_rdata = '0;
        end else if (afp.l2_mem_resp) begin
            afp.l2_mem_resp = 1'b0; cnt_fp = 0;
        end else if (afp.l2_read || afp.l2_write) begin
            cnt_fp++;
            if (cnt_fp >= lat_fp) begin
                afp.l2_mem_resp = 1'b1;
                afp.l2_rdata    = {8{afp.l2_address}};
            end
        end else cnt_fp = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_p4 = 0; a4.l2_mem_resp = 1'b0; a4.l2_rdata = '0;
        end else if (a4.l2_mem_resp) begin
            a4.l2_mem_resp = 1'b0; cnt_p4 = 0;
        end else if (a4.l2_read || a4.l2_write) begin
            cnt_p4++;
            if (cnt_p4 >= lat_p4) begin
                a4.l2_mem_resp = 1'b1;
                a4.l2_rdata    = {8{a4.l2_address}};
            end
        end else cnt_p4 = 0;
    end

    // Bounded waits for a response pulse, observed on the falling edge.
    task automatic wait_resp_rr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (a2.port_resp != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_resp_fp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (afp.port_resp != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_resp_p4(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (a4.port_resp != '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a2.port_read = '0;  a2.port_write = '0;  a2.port_address = '0;  a2.port_wdata = '0;
        afp.port_read = '0; afp.port_write = '0; afp.port_address = '0; afp.port_wdata = '0;
        a4.port_read = '0;  a4.port_write = '0;  a4.port_address = '0;  a4.port_wdata = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (a2.l2_read !== 1'b0) begin n_fail++; $display("FAIL rst_l2_read got %b want 0", a2.l2_read); end
        n_checks++; if (a2.l2_write !== 1'b0) begin n_fail++; $display("FAIL rst_l2_write got %b want 0", a2.l2_write); end
        n_checks++; if (a2.l2_address !== 16'h0) begin n_fail++; $display("FAIL rst_l2_address got %h want 0", a2.l2_address); end
        n_checks++; if (a2.l2_wdata !== 128'h0) begin n_fail++; $display("FAIL rst_l2_wdata got %h want 0", a2.l2_wdata); end
        n_checks++; if (a2.port_resp !== 2'b00) begin n_fail++; $display("FAIL rst_port_resp got %b want 00", a2.port_resp); end
        n_checks++; if (a2.port_rdata !== 128'h0) begin n_fail++; $display("FAIL rst_port_rdata got %h want 0", a2.port_rdata); end
        n_checks++; if (a4.port_resp !== 4'b0000) begin n_fail++; $display("FAIL rst_p4_resp got %b want 0000", a4.port_resp); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        bit ok;
        int cycles;
        lat_rr = 5;
        key_rr = {4{32'hDEADBEEF}};
        a2.port_address[15:0] = 16'h1230;
        a2.port_read[0]       = 1'b1;
        @(negedge clk);
        n_checks++; if (a2.l2_read !== 1'b1) begin n_fail++; $display("FAIL sr_strobe_latency got %b want 1", a2.l2_read); end
        n_checks++; if (a2.l2_address !== 16'h1230) begin n_fail++; $display("FAIL sr_l2_address got %h want 1230", a2.l2_address); end
        n_checks++; if (a2.l2_write !== 1'b0) begin n_fail++; $display("FAIL sr_l2_write got %b want 0", a2.l2_write); end
        cycles = 1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (a2.port_resp != '0) ok = 1'b1;
            else if (a2.l2_read) cycles++;
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sr_timeout got no resp want resp"); end
        n_checks++; if (cycles != 5) begin n_fail++; $display("FAIL sr_read_cycles got %0d want 5", cycles); end
        n_checks++; if (a2.port_resp !== 2'b01) begin n_fail++; $display("FAIL sr_port_resp got %b want 01", a2.port_resp); end
        n_checks++; if (a2.port_rdata !== ({8{16'h1230}} ^ {4{32'hDEADBEEF}})) begin
            n_fail++; $display("FAIL sr_port_rdata got %h want %h", a2.port_rdata, {8{16'h1230}} ^ {4{32'hDEADBEEF}}); end
        a2.port_read[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (a2.port_resp !== 2'b00) begin n_fail++; $display("FAIL sr_resp_pulse got %b want 00", a2.port_resp); end
        n_checks++; if (a2.l2_read !== 1'b0) begin n_fail++; $display("FAIL sr_read_cleared got %b want 0", a2.l2_read); end
    endtask

    task automatic test_round_robin;
        bit           ok;
        logic [1:0]   exp_oh [4];
        logic [15:0]  exp_ad [4];
        exp_oh = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_ad = '{16'h0100, 16'h0200, 16'h0100, 16'h0200};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        lat_rr = 2;
        key_rr = '0;
        a2.port_address = {16'h0200, 16'h0100};
        a2.port_read    = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_resp_rr(ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_timeout_%0d got no resp want resp", t); end
            n_checks++; if (a2.port_resp !== exp_oh[t]) begin n_fail++; $display("FAIL rr_grant_%0d got %b want %b", t, a2.port_resp, exp_oh[t]); end
            n_checks++; if (a2.port_rdata !== {8{exp_ad[t]}}) begin n_fail++; $display("FAIL rr_rdata_%0d got %h want %h", t, a2.port_rdata, {8{exp_ad[t]}}); end
            @(negedge clk);
            n_checks++; if (a2.port_resp !== 2'b00) begin n_fail++; $display("FAIL rr_pulse_%0d got %b want 00", t, a2.port_resp); end
        end
        a2.port_read = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_hold;
        bit ok;
        lat_rr = 6;
        key_rr = {4{32'hA5A5A5A5}};
        a2.port_address[31:16] = 16'h4000;
        a2.port_wdata[255:128] = {8{16'h5555}};
        a2.port_read[1]        = 1'b1;
        a2.port_write[1]       = 1'b1;
        @(negedge clk);
        n_checks++; if (a2.l2_write !== 1'b1) begin n_fail++; $display("FAIL wh_write_start got %b want 1", a2.l2_write); end
        a2.port_address[31:16] = 16'h7777;
        a2.port_wdata[255:128] = {8{16'hAAAA}};
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (a2.port_resp != '0) ok = 1'b1;
            else begin
                n_checks++; if (a2.l2_address !== 16'h4000) begin n_fail++; $display("FAIL wh_address got %h want 4000", a2.l2_address); end
                n_checks++; if (a2.l2_write !== 1'b1) begin n_fail++; $display("FAIL wh_write got %b want 1", a2.l2_write); end
                n_checks++; if (a2.l2_read !== 1'b0) begin n_fail++; $display("FAIL wh_read got %b want 0", a2.l2_read); end
                n_checks++; if (a2.l2_wdata !== {8{16'h5555}}) begin n_fail++; $display("FAIL wh_wdata got %h want 5555..", a2.l2_wdata); end
            end
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wh_timeout got no resp want resp"); end
        n_checks++; if (a2.port_resp !== 2'b10) begin n_fail++; $display("FAIL wh_port_resp got %b want 10", a2.port_resp); end
        n_checks++; if (a2.l2_write !== 1'b0) begin n_fail++; $display("FAIL wh_write_cleared got %b want 0", a2.l2_write); end
        a2.port_read  = 2'b00;
        a2.port_write = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed_priority;
        bit ok;
        afp.port_address = {16'h0B00, 16'h0A00};
        afp.port_read    = 2'b11;
        for (int t = 0; t < 3; t++) begin
            wait_resp_fp(ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fp_timeout_%0d got no resp want resp", t); end
            n_checks++; if (afp.port_resp !== 2'b01) begin n_fail++; $display("FAIL fp_grant_%0d got %b want 01", t, afp.port_resp); end
        end
        afp.port_read[0] = 1'b0;
        wait_resp_fp(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fp_timeout_p1 got no resp want resp"); end
        n_checks++; if (afp.port_resp !== 2'b10) begin n_fail++; $display("FAIL fp_grant_p1 got %b want 10", afp.port_resp); end
        n_checks++; if (afp.port_rdata !== {8{16'h0B00}}) begin n_fail++; $display("FAIL fp_rdata_p1 got %h want %h", afp.port_rdata, {8{16'h0B00}}); end
        afp.port_read = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_four_port;
        bit ok;
        a4.port_address = {16'h0333, 16'h0222, 16'h0111, 16'h0000};
        a4.port_read    = 4'b0100;
        wait_resp_p4(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL p4_timeout_p2 got no resp want resp"); end
        n_checks++; if (a4.port_resp !== 4'b0100) begin n_fail++; $display("FAIL p4_grant_p2 got %b want 0100", a4.port_resp); end
        a4.port_read = 4'b1010;
        wait_resp_p4(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL p4_timeout_p3 got no resp want resp"); end
        n_checks++; if (a4.port_resp !== 4'b1000) begin n_fail++; $display("FAIL p4_grant_wrap got %b want 1000", a4.port_resp); end
        a4.port_read[3] = 1'b0;
        wait_resp_p4(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL p4_timeout_p1 got no resp want resp"); end
        n_checks++; if (a4.port_resp !== 4'b0010) begin n_fail++; $display("FAIL p4_grant_p1 got %b want 0010", a4.port_resp); end
        n_checks++; if (a4.port_rdata !== {8{16'h0111}}) begin n_fail++; $display("FAIL p4_rdata_p1 got %h want %h", a4.port_rdata, {8{16'h0111}}); end
        a4.port_read = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_issue;
        bit ok;
        lat_rr = 2;
        key_rr = '0;
        a2.port_address = {16'h0600, 16'h0500};
        a2.port_read    = 2'b01;
        wait_resp_rr(ok);
        n_checks++; if (a2.port_resp !== 2'b01) begin n_fail++; $display("FAIL rm_pre_grant got %b want 01", a2.port_resp); end
        lat_rr       = 20;
        a2.port_read = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (a2.l2_read) ok = 1'b1;
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rm_no_strobe got 0 want 1"); end
        n_checks++; if (a2.l2_address !== 16'h0600) begin n_fail++; $display("FAIL rm_rr_winner got %h want 0600", a2.l2_address); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (a2.l2_read !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop got %b want 0", a2.l2_read); end
        n_checks++; if (a2.port_resp !== 2'b00) begin n_fail++; $display("FAIL rm_resp_in_reset got %b want 00", a2.port_resp); end
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (a2.port_resp !== 2'b00) begin n_fail++; $display("FAIL rm_resp_held got %b want 00", a2.port_resp); end
        end
        lat_rr = 2;
        rst_n  = 1'b1;
        wait_resp_rr(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rm_timeout got no resp want resp"); end
        n_checks++; if (a2.port_resp !== 2'b01) begin n_fail++; $display("FAIL rm_first_after_reset got %b want 01", a2.port_resp); end
        a2.port_read = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_fixed_priority();
        test_four_port();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Parametrised N-port arbiter that shares a single cache-line-wide L2 memory port among several L1 requesters (I-cache, D-cache, and later prefetch or victim buffers). Each requester sees a private read/write/response handshake. The arbiter grants one port at a time, in round-robin or fixed-priority order. It holds the grant and forwards one complete transaction to L2, then returns a one-cycle response and read data to the winner. It sits between the L1 caches and the L2 interface at the top level, replacing direct L1-to-L2 wiring.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters (≥1)
- ADDR_WIDTH, 16, byte address width
- LINE_WIDTH, 128, cache line width in bits
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- port_read  in  NUM_PORTS  per-port line read request, held until that port's resp
- port_write  in  NUM_PORTS  per-port line write request, held until that port's resp
- port_address  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- port_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line, packed the same way
- port_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse
- port_rdata  out  LINE_WIDTH  shared registered read line, valid when any port_resp is high
- l2_address  out  ADDR_WIDTH  address to L2
- l2_read  out  1  L2 read strobe
- l2_write  out  1  L2 write strobe
- l2_wdata  out  LINE_WIDTH  write line to L2
- l2_mem_resp  in  1  L2 completion, one cycle
- l2_rdata  in  LINE_WIDTH  L2 read line, valid with l2_mem_resp

## Operation
- A port requests when port_read[i] | port_write[i] is high.
- If both read and write are high on a port, the write is forwarded and the read is ignored for that transaction.
- FSM states: IDLE, ISSUE, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, any request:
  - Select a winner and latch its address, wdata and operation into output registers.
  - Record grant = winner.
  - Go to ISSUE.
- ISSUE:
  - Hold l2_read or l2_write and the latched address/data constant.
  - Requester inputs are not re-sampled; changes on them are ignored.
  - On l2_mem_resp: latch l2_rdata into port_rdata, clear l2_read/l2_write, set port_resp[grant], go to DONE.
- DONE (exactly one cycle):
  - port_resp[grant] is high.
  - No new grant is made, so the winner can drop its request.
  - Clear port_resp and go to IDLE.
- Round-robin (ARB_MODE=0):
  - Search starts at (last_grant+1) mod NUM_PORTS and wraps.
  - last_grant updates when entering DONE.
- Fixed priority (ARB_MODE=1): the lowest requesting index wins, and last_grant is unused.
- Write transactions still latch l2_rdata on completion; the contents are don't-care for the requester.
- NUM_PORTS=1: degenerates to a registered pass-through with the same latency.

## Timing
- Reset values (rst_n low, asynchronous):
  - State = IDLE.
  - l2_read = l2_write = 0.
  - l2_address = 0, l2_wdata = 0.
  - port_resp = 0, port_rdata = 0.
  - last_grant = NUM_PORTS-1, so port 0 is first after reset.
- Request first seen high at edge k in IDLE → L2 strobe high from cycle k+1.
- l2_mem_resp sampled at edge m → port_resp high during cycle m+1 (DONE) → IDLE at m+2.
- Earliest next grant is sampled at edge m+2; minimum turnaround is 3 cycles per transaction beyond L2 latency.
- l2_mem_resp is ignored in IDLE and DONE.
- Simultaneous requests in IDLE: exactly one grant per the mode rule; losers wait with no side effect.
- Reset asserted mid-ISSUE: L2 strobes drop immediately (asynchronously), the transaction is abandoned, and no port_resp is issued.
- last_grant arithmetic is modulo NUM_PORTS: index NUM_PORTS-1 wraps to 0.

## Structure
- Shared package lc3b_types:
  - lc3b_cache_line (existing).
  - New enum l2_arb_state_t {IDLE, ISSUE, DONE}.
- Sub-module rr_select: combinational rotating-priority selector.
  - Inputs: req[NUM_PORTS], base index.
  - Outputs: one-hot grant, grant index, any-valid flag.
  - Fixed mode drives base = 0.
- The remaining logic (FSM, output and data registers, last_grant) lives in l2_arbiter.

## Test plan
- Single read on port 0 to address 0x1230; L2 answers after 4 cycles with line 0xDEADBEEF… → l2_read high for 5 cycles, port_resp = 2'b01 for one cycle, port_rdata matches the L2 line.
- Ports 0 and 1 both read continuously in round-robin mode → grants alternate 0,1,0,1; each port_resp is a one-cycle pulse; no back-to-back grant to the same port while the other waits.
- ARB_MODE=1 with both ports requesting for 3 transactions → port 0 is granted every time; port 1 is granted only after port 0 drops.
- Port 1 write with address 0x4000 and wdata 0x55…55, then port 1 changes its address mid-ISSUE → l2_address stays 0x4000, l2_write stays high until resp, l2_read stays low.
- NUM_PORTS=4, ports 1 and 3 requesting, last_grant=2 → port 3 is granted first, then port 1.
- rst_n pulled low during ISSUE → l2_read falls without a clock edge, port_resp stays 0, and after release port 0 wins the first grant.
